// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter sharing one 8:1 single-bit mux channel between eight
//   bit-serial requesters. Grants are bounded to HOLD_MAX consecutive cycles.
//   The winner's data bit is re-registered onto dout.
//
// Parameters
//   HOLD_MAX : maximum consecutive grant cycles per owner (1..255)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req[7:0] in   per-source request, held high while the channel is wanted
//   lock     in   extend the current grant past HOLD_MAX (optional feature)
//   din[7:0] in   one data bit per source
//   gnt[7:0] out  one-hot grant, zero when idle
//   sel[2:0] out  index of the current/last owner (mux select)
//   busy     out  channel owned this cycle
//   dout     out  registered muxed data
//   dout_vld out  dout carries owner data
//
// Build option
//   MUX8_ARB_LOCK_EN : when defined, lock=1 with req[sel]=1 suppresses the
//                      HOLD_MAX expiry. Otherwise lock is ignored.

module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       lock,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       dout,
  output logic       dout_vld
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int            CW      = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

  logic [0:0]    state_reg, state_next;
  logic [2:0]    sel_reg, sel_next;
  logic [2:0]    ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          dout_reg, dout_vld_reg;

  logic          grant_active;
  logic [2:0]    base;
  logic [7:0]    rot_req;
  logic [2:0]    offset;
  logic          found;
  logic [2:0]    winner;
  logic          lock_ext;
  logic          release_now;

  assign grant_active = (state_reg == ST_GRANT);

  // While granted, the only time the search result is used is on a release,
  // and then the new pointer is sel+1. Searching from sel+1 directly lets the
  // re-arbitration happen in the same cycle and puts the expiring owner last.
  assign base = grant_active ? (sel_reg + 3'd1) : ptr_reg;

  // Rotate req so that bit 0 is the highest-priority index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[base + 3'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the winner offset.
  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) offset = 3'(k);
    end
  end

  assign found  = |req;
  assign winner = base + offset;

`ifdef MUX8_ARB_LOCK_EN
  assign lock_ext = lock & req[sel_reg];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_ext    = 1'b0;
`endif

  assign release_now = grant_active &
                       (~req[sel_reg] | ((cnt_reg == CNT_MAX) & ~lock_ext));

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    if (!grant_active) begin
      if (found) begin
        state_next = ST_GRANT;
        sel_next   = winner;
        cnt_next   = CW'(1);
      end
    end else if (release_now) begin
      ptr_next = sel_reg + 3'd1;
      if (found) begin
        sel_next = winner;
        cnt_next = CW'(1);
      end else begin
        state_next = ST_IDLE;
      end
    end else begin
      cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      sel_reg      <= 3'd0;
      ptr_reg      <= 3'd0;
      cnt_reg      <= '0;
      dout_reg     <= 1'b0;
      dout_vld_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      // Data path uses the owner registered before this edge.
      dout_reg     <= grant_active ? din[sel_reg] : 1'b0;
      dout_vld_reg <= grant_active;
    end
  end

  assign busy     = grant_active;
  assign sel      = sel_reg;
  assign gnt      = grant_active ? (8'b1 << sel_reg) : 8'b0;
  assign dout     = dout_reg;
  assign dout_vld = dout_vld_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       lock;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       dout;
  logic       dout_vld;

  int total = 0;
  int bad   = 0;

  mux8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .din      (din),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       dv;   // expected dout and dout_vld (equal with this din)
  } vec_t;

  vec_t tbl[11];

  // Reference model: owner index (-1 = idle), rotation start, hold count.
  int m_owner, m_ptr, m_cnt, m_sel;
  logic m_dout, m_vld;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    din   = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
    m_dout = 1'b0; m_vld = 1'b0;
  endtask

  function automatic int search(input int p, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int  w;
    bit  lk;
    m_vld  = (m_owner >= 0);
    m_dout = m_vld ? din[m_owner] : 1'b0;
`ifdef MUX8_ARB_LOCK_EN
    lk = (m_owner >= 0) && lock && req[m_owner];
`else
    lk = 1'b0;
`endif
    if (m_owner < 0) begin
      w = search(m_ptr, req);
      if (w >= 0) begin m_owner = w; m_cnt = 1; end
    end else if (!req[m_owner] || (m_cnt >= HOLD && !lk)) begin
      m_ptr = (m_owner + 1) % 8;
      w = search(m_ptr, req);
      if (w >= 0) begin m_owner = w; m_cnt = 1; end
      else m_owner = -1;
    end else begin
      m_cnt = (m_cnt < HOLD) ? m_cnt + 1 : HOLD;
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  initial begin
    // Directed vectors from reset: single requester re-grant, idle, early drop.
    tbl[0]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[1]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[2]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[3]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[4]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b1};  // expiry, sole requester re-granted
    tbl[5]  = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b1};  // idle, sel kept
    tbl[6]  = '{8'h24, 8'h20, 3'd5, 1'b1, 1'b0};  // search from ptr=4 -> 5
    tbl[7]  = '{8'h24, 8'h20, 3'd5, 1'b1, 1'b1};
    tbl[8]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1};  // req[5] drops -> 6,7,0,1,2
    tbl[9]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b1};

    // Reset with all requests high.
    rst_n = 1'b0; req = 8'hFF; lock = 1'b0; din = 8'hFF;
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_vld", int'(dout_vld), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_first_gnt", int'(gnt), 8'h01);
    $display("reset: gnt=%h after first edge", gnt);

    // Table-driven vectors.
    do_reset();
    din = 8'h2C;
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      tick();
      $display("vec %0d: req=%h gnt=%h sel=%0d busy=%0d dout=%0d vld=%0d",
               i, req, gnt, sel, busy, dout, dout_vld);
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("vec%0d_sel", i), int'(sel), int'(tbl[i].sel));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d_dout", i), int'(dout), int'(tbl[i].dv));
      chk($sformatf("vec%0d_vld", i), int'(dout_vld), int'(tbl[i].dv));
    end

    // Full load: each owner for exactly HOLD cycles, no idle bubble.
    do_reset();
    req = 8'hFF;
    for (int t = 0; t < 8 * HOLD + 1; t++) begin
      tick();
      chk($sformatf("full%0d_sel", t), int'(sel), (t / HOLD) % 8);
      chk($sformatf("full%0d_busy", t), int'(busy), 1);
    end
    $display("full load: sel=%0d after %0d cycles", sel, 8 * HOLD + 1);

    // Lock: owner 1 with req=03.
    do_reset();
    req = 8'h02;
    tick();
    chk("lock_start_gnt", int'(gnt), 8'h02);
    req = 8'h03; lock = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
`ifdef MUX8_ARB_LOCK_EN
      chk($sformatf("lock%0d_gnt", k), int'(gnt), 8'h02);
`else
      if (k <= HOLD - 1) chk($sformatf("nolock%0d_gnt", k), int'(gnt), 8'h02);
      if (k == HOLD)     chk($sformatf("nolock%0d_gnt", k), int'(gnt), 8'h01);
`endif
    end
`ifdef MUX8_ARB_LOCK_EN
    lock = 1'b0;
    tick();
    chk("lock_fall_gnt", int'(gnt), 8'h01);
`endif
    $display("lock: gnt=%h at end", gnt);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 8'h10; din = 8'hFF;
    tick();
    tick();
    chk("ar_pre_gnt", int'(gnt), 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", int'(gnt), 0);
    chk("ar_sel", int'(sel), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_dout", int'(dout), 0);
    chk("ar_vld", int'(dout_vld), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_post_gnt", int'(gnt), 8'h10);
    $display("async reset: gnt=%h after release", gnt);

    // Randomized stimulus against the reference model.
    do_reset();
    req = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) req = 8'($urandom);
      din  = 8'($urandom);
      lock = ($urandom_range(3) != 0);
      model_step();
      tick();
      chk($sformatf("rnd%0d_gnt", n), int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      chk($sformatf("rnd%0d_sel", n), int'(sel), m_sel);
      chk($sformatf("rnd%0d_busy", n), int'(busy), (m_owner >= 0) ? 1 : 0);
      chk($sformatf("rnd%0d_dout", n), int'(dout), int'(m_dout));
      chk($sformatf("rnd%0d_vld", n), int'(dout_vld), int'(m_vld));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

- Round-robin arbiter that shares one 8:1 single-bit mux channel between eight requesters.
- Generates the 3-bit mux select and a one-hot grant, and enforces a bounded hold time per grant.
- Contains a registered copy of the muxed data path.
- Sits between the eight bit-serial sources and the shared downstream consumer.

## Interface
- HOLD_MAX, 4: maximum consecutive cycles one requester may own the channel (legal range 1..255).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  8  request per source; must stay high while the source wants the channel.
- lock  input  1  extend the current grant past HOLD_MAX. Only honoured when MUX8_ARB_LOCK_EN is defined.
- din  input  8  one data bit per source; din[i] is source i.
- gnt  output  8  one-hot grant, all-zero when idle.
- sel  output  3  binary index of the owner; drives the mux select.
- busy  output  1  channel owned this cycle.
- dout  output  1  registered muxed data.
- dout_vld  output  1  dout carries owner data.

## Operation
- Reset value of every output: gnt=0, sel=0, busy=0, dout=0, dout_vld=0. Internal state on reset: ptr=0, cnt=0, state IDLE.
- States:
  - IDLE: busy=0, gnt=0.
  - GRANT: busy=1, gnt=1<<sel.
- Arbitration search: scan req starting at index ptr, wrapping 7→0; first set bit wins.
- IDLE→GRANT: on an edge where req≠0.
  - sel←winner, gnt←onehot(winner), cnt←1.
- Release condition in GRANT, evaluated each edge:
  - req[sel]=0, or
  - cnt==HOLD_MAX and not lock-extended.
- On release:
  - ptr←(sel+1) mod 8.
  - Arbitrate the same edge using the new ptr over the current req.
  - Winner found → stay in GRANT, new sel/gnt, cnt←1. No idle bubble between owners.
  - No winner → IDLE, gnt←0. sel keeps its last value.
- A requester that expired HOLD_MAX while still requesting has lowest priority. If it is the only requester, it is re-granted with cnt←1.
- No release: cnt←cnt+1, saturating at HOLD_MAX.
- Counter width: $clog2(HOLD_MAX+1).
- Data path, every edge:
  - dout←busy ? din[sel] : 0.
  - dout_vld←busy.
  - Both use the registered sel/busy values before the edge.
- Multi-bit req changes and simultaneous drop/expiry need no special handling; the release condition is a single OR.
- Reset asserted mid-grant: all outputs clear immediately (asynchronous); ptr returns to 0.

## Timing
- Grant latency: req rises before edge N → gnt/sel/busy valid after edge N (1 cycle).
- Release latency: req[sel] drops before edge N → gnt moves or clears after edge N.
- Hold: owner sees gnt for exactly HOLD_MAX cycles while requesting, unless lock-extended.
- Data latency: din[sel] sampled at edge N appears on dout after edge N; dout trails gnt by one cycle.
- Reset release: first arbitration on the first rising edge with rst_n=1.

## Configuration
- MUX8_ARB_LOCK_EN defined:
  - While busy=1, lock=1 and req[sel]=1, the HOLD_MAX expiry is ignored.
  - cnt stays saturated at HOLD_MAX.
  - Release happens when lock falls (if cnt==HOLD_MAX) or when req[sel] drops.
- MUX8_ARB_LOCK_EN undefined:
  - The lock port exists but is ignored.
  - Grants always end at HOLD_MAX.

## Test plan
- Reset: drive rst_n=0 with req=8'hFF → gnt=0, sel=0, busy=0, dout=0, dout_vld=0. Release reset → gnt=8'h01 after the first edge.
- Single requester: req=8'h08 held 10 cycles, HOLD_MAX=4, din=8'h08.
  - gnt=8'h08, sel=3 one cycle after req rises; stays continuously (re-granted at each expiry).
  - dout=1 and dout_vld=1 one cycle after gnt.
- Full load: req=8'hFF constant.
  - sel sequence 0,1,…,7,0, each held exactly 4 cycles, with busy never low.
- Early drop: owner 5 (ptr then 6), req=8'h24; req[5] drops after 2 grant cycles.
  - Next edge: gnt=8'h04, sel=2 (search 6,7,0,1,2).
- Lock (macro defined): owner 1 with lock=1 and req=8'h03 for 10 cycles.
  - gnt stays 8'h02 for all 10 cycles.
  - lock→0 → gnt=8'h01 next edge.
  - Without the macro: gnt switches to 8'h01 after 4 cycles.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=8'h10.
  - All outputs zero immediately.
  - After release with req=8'h10 → gnt=8'h10 (ptr reset to 0).
